// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer: states, ALU encodings,
// opcode constants, instruction field positions and the decoder output bundle.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SHL = 3'b010,
        ALU_NOP = 3'b111
    } alu_op_e;

    localparam int INSTR_W    = 32;
    localparam int OPC_W      = 6;
    localparam int REG_ADDR_W = 5;
    localparam int IMM_W      = 11;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 10;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OPC_ADDI   = 6'b110000;
    localparam logic [OPC_W-1:0] OPC_SUBI   = 6'b111000;
    localparam logic [OPC_W-1:0] OPC_ADD    = 6'b010000;
    localparam logic [OPC_W-1:0] OPC_SHIFTL = 6'b100000;
    localparam logic [OPC_W-1:0] OPC_BEQ    = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_J      = 6'b000010;
    localparam logic [OPC_W-1:0] OPC_NOP    = 6'b000000;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src_imm;
        logic    writes;
        logic    is_jump;
        logic    is_branch;
        logic    illegal;
    } decode_t;

    function automatic logic [INSTR_W-1:0] zext_imm(input logic [IMM_W-1:0] field);
        return {{(INSTR_W-IMM_W){1'b0}}, field};
    endfunction

endpackage

// File: rtl/multicycle_sequencer_decoder.sv
// Purely combinational opcode decoder: maps ir[31:26] to the ALU controls
// and the flags that steer the sequencer through EXEC/WB.
module opcode_decoder
    import multicycle_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output decode_t          decode_o
);

    // Unknown opcodes fall through as a NOP with the illegal flag raised.
    always_comb begin
        decode_o.alu_op      = ALU_NOP;
        decode_o.alu_src_imm = 1'b0;
        decode_o.writes      = 1'b0;
        decode_o.is_jump     = 1'b0;
        decode_o.is_branch   = 1'b0;
        decode_o.illegal     = 1'b0;
        case (opcode_i)
            OPC_ADDI: begin
                decode_o.alu_op      = ALU_ADD;
                decode_o.alu_src_imm = 1'b1;
                decode_o.writes      = 1'b1;
            end
            OPC_SUBI: begin
                decode_o.alu_op      = ALU_SUB;
                decode_o.alu_src_imm = 1'b1;
                decode_o.writes      = 1'b1;
            end
            OPC_ADD: begin
                decode_o.alu_op = ALU_ADD;
                decode_o.writes = 1'b1;
            end
            OPC_SHIFTL: begin
                decode_o.alu_op = ALU_SHL;
                decode_o.writes = 1'b1;
            end
            OPC_BEQ: begin
                decode_o.alu_op    = ALU_SUB;
                decode_o.is_branch = 1'b1;
            end
            OPC_J: begin
                decode_o.is_jump = 1'b1;
            end
            OPC_NOP: begin
            end
            default: begin
                decode_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH -> DECODE -> EXEC [-> WB], driving the
// instruction address, the instruction register fields and the datapath controls.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int              PC_W     = 5,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [INSTR_W-1:0]    instr_i,
    input  logic                  alu_zero_i,
    output logic [PC_W-1:0]       pc_o,
    output logic [INSTR_W-1:0]    ir_o,
    output logic [REG_ADDR_W-1:0] rs_addr_o,
    output logic [REG_ADDR_W-1:0] rt_addr_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [INSTR_W-1:0]    imm_o,
    output logic [2:0]            alu_op_o,
    output logic                  alu_src_imm_o,
    output logic                  reg_write_o,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic                  illegal_o
);

    state_e               state_q;
    logic [PC_W-1:0]      pc_q;
    logic [INSTR_W-1:0]   ir_q;
    alu_op_e              alu_op_q;
    logic                 alu_src_imm_q;
    logic                 writes_q;
    logic                 is_jump_q;
    logic                 is_branch_q;
    logic                 reg_write_q;
    logic                 busy_q;
    logic                 halted_q;
    logic                 illegal_q;

    decode_t              dec;
    logic                 take_d;
    logic                 halt_d;
    logic [PC_W-1:0]      pc_d;

    opcode_decoder u_decoder (
        .opcode_i (ir_q[OPC_MSB:OPC_LSB]),
        .decode_o (dec)
    );

    // Retirement target: only consulted on the cycle an instruction completes.
    // Running off the top of the address space halts instead of wrapping.
    always_comb begin
        take_d = is_jump_q | (is_branch_q & alu_zero_i);
        pc_d   = take_d ? ir_q[PC_W-1:0] : pc_q + 1'b1;
        halt_d = ~take_d & (pc_q == {PC_W{1'b1}});
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            alu_op_q      <= ALU_NOP;
            alu_src_imm_q <= 1'b0;
            writes_q      <= 1'b0;
            is_jump_q     <= 1'b0;
            is_branch_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start_i) begin
                        state_q   <= ST_FETCH;
                        pc_q      <= RESET_PC;
                        illegal_q <= 1'b0;
                        busy_q    <= 1'b1;
                        halted_q  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    ir_q    <= instr_i;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    alu_op_q      <= dec.alu_op;
                    alu_src_imm_q <= dec.alu_src_imm;
                    writes_q      <= dec.writes;
                    is_jump_q     <= dec.is_jump;
                    is_branch_q   <= dec.is_branch;
                    if (dec.illegal) begin
                        illegal_q <= 1'b1;
                    end
                    state_q <= ST_EXEC;
                end
                // Writing instructions retire from WB so the strobe lands there.
                ST_EXEC: begin
                    if (writes_q) begin
                        state_q     <= ST_WB;
                        reg_write_q <= 1'b1;
                    end else if (halt_d) begin
                        state_q  <= ST_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q    <= pc_d;
                        state_q <= ST_FETCH;
                    end
                end
                ST_WB: begin
                    if (halt_d) begin
                        state_q  <= ST_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q    <= pc_d;
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign ir_o          = ir_q;
    assign rs_addr_o     = ir_q[RS_MSB:RS_LSB];
    assign rt_addr_o     = ir_q[RT_MSB:RT_LSB];
    assign rd_addr_o     = ir_q[RD_MSB:RD_LSB];
    assign imm_o         = zext_imm(ir_q[IMM_MSB:IMM_LSB]);
    assign alu_op_o      = alu_op_q;
    assign alu_src_imm_o = alu_src_imm_q;
    assign reg_write_o   = reg_write_q;
    assign busy_o        = busy_q;
    assign halted_o      = halted_q;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed program walk, reset abort, then a
// random program checked instruction-by-instruction against an ISA-level model.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        alu_zero;
    logic [31:0] instr;
    logic [4:0]  pc;
    logic [31:0] ir;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [4:0]  rdAddr;
    logic [31:0] imm;
    logic [2:0]  aluOp;
    logic        aluSrcImm;
    logic        regWrite;
    logic        busy;
    logic        halted;
    logic        illegal;

    logic [31:0] imem [32];

    int total = 0;
    int bad   = 0;

    logic [4:0] mPc;
    logic       mIllegal;
    logic       mHalted;

    typedef struct packed {
        logic [2:0] aluOp;
        logic       srcImm;
        logic       writes;
        logic       isJ;
        logic       isB;
        logic       bad;
    } ref_t;

    assign instr = imem[pc];

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .instr_i       (instr),
        .alu_zero_i    (alu_zero),
        .pc_o          (pc),
        .ir_o          (ir),
        .rs_addr_o     (rsAddr),
        .rt_addr_o     (rtAddr),
        .rd_addr_o     (rdAddr),
        .imm_o         (imm),
        .alu_op_o      (aluOp),
        .alu_src_imm_o (aluSrcImm),
        .reg_write_o   (regWrite),
        .busy_o        (busy),
        .halted_o      (halted),
        .illegal_o     (illegal)
    );

    // Instruction-set table: what each opcode should look like to the datapath.
    function automatic ref_t refDecode(input logic [5:0] op);
        ref_t r;
        r.aluOp  = 3'b111;
        r.srcImm = 1'b0;
        r.writes = 1'b0;
        r.isJ    = 1'b0;
        r.isB    = 1'b0;
        r.bad    = 1'b0;
        case (op)
            6'b110000: begin r.aluOp = 3'b000; r.srcImm = 1'b1; r.writes = 1'b1; end
            6'b111000: begin r.aluOp = 3'b001; r.srcImm = 1'b1; r.writes = 1'b1; end
            6'b010000: begin r.aluOp = 3'b000; r.writes = 1'b1; end
            6'b100000: begin r.aluOp = 3'b010; r.writes = 1'b1; end
            6'b001000: begin r.aluOp = 3'b001; r.isB = 1'b1; end
            6'b000010: r.isJ = 1'b1;
            6'b000000: ;
            default:   r.bad = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [10:0] im);
        return {op, rs, rt, rd, im};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic startVal, input logic zeroVal);
        start    = startVal;
        alu_zero = zeroVal;
    endtask

    task automatic checkResetValues(input string where);
        checkOutput({where, "_pc"}, {27'd0, pc}, 32'd0);
        checkOutput({where, "_ir"}, ir, 32'd0);
        checkOutput({where, "_aluop"}, {29'd0, aluOp}, 32'd7);
        checkOutput({where, "_srcimm"}, {31'd0, aluSrcImm}, 32'd0);
        checkOutput({where, "_regwrite"}, {31'd0, regWrite}, 32'd0);
        checkOutput({where, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({where, "_halted"}, {31'd0, halted}, 32'd0);
        checkOutput({where, "_illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    task automatic doStart;
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        mPc      = 5'd0;
        mIllegal = 1'b0;
        mHalted  = 1'b0;
    endtask

    // Run one instruction from its FETCH cycle to the first cycle after it retires.
    task automatic runInstr(input logic az, input logic pokeStart);
        logic [31:0] w;
        ref_t        r;
        logic        take;
        logic        halt;
        logic [4:0]  nextPc;
        w = imem[mPc];
        r = refDecode(w[31:26]);
        checkOutput("fetch_pc", {27'd0, pc}, {27'd0, mPc});
        checkOutput("fetch_busy", {31'd0, busy}, 32'd1);
        tick();
        if (pokeStart) applyStimulus(1'b1, 1'b0);
        checkOutput("decode_regwrite", {31'd0, regWrite}, 32'd0);
        tick();
        applyStimulus(1'b0, az);
        mIllegal = mIllegal | r.bad;
        checkOutput("exec_ir", ir, w);
        checkOutput("exec_aluop", {29'd0, aluOp}, {29'd0, r.aluOp});
        checkOutput("exec_srcimm", {31'd0, aluSrcImm}, {31'd0, r.srcImm});
        checkOutput("exec_rs", {27'd0, rsAddr}, {27'd0, w[25:21]});
        checkOutput("exec_rt", {27'd0, rtAddr}, {27'd0, w[20:16]});
        checkOutput("exec_rd", {27'd0, rdAddr}, {27'd0, w[15:11]});
        checkOutput("exec_imm", imm, {21'd0, w[10:0]});
        checkOutput("exec_regwrite", {31'd0, regWrite}, 32'd0);
        checkOutput("exec_illegal", {31'd0, illegal}, {31'd0, mIllegal});
        checkOutput("exec_pc", {27'd0, pc}, {27'd0, mPc});
        if (r.writes) begin
            tick();
            checkOutput("wb_regwrite", {31'd0, regWrite}, 32'd1);
            checkOutput("wb_aluop", {29'd0, aluOp}, {29'd0, r.aluOp});
            checkOutput("wb_pc", {27'd0, pc}, {27'd0, mPc});
        end
        tick();
        applyStimulus(1'b0, 1'b0);
        take   = r.isJ | (r.isB & az);
        nextPc = take ? w[4:0] : mPc + 5'd1;
        halt   = ~take & (mPc == 5'd31);
        checkOutput("retire_regwrite", {31'd0, regWrite}, 32'd0);
        checkOutput("retire_illegal", {31'd0, illegal}, {31'd0, mIllegal});
        checkOutput("retire_halted", {31'd0, halted}, {31'd0, halt});
        checkOutput("retire_busy", {31'd0, busy}, {31'd0, ~halt});
        if (halt) begin
            checkOutput("halt_pc", {27'd0, pc}, {27'd0, mPc});
            mHalted = 1'b1;
        end else begin
            checkOutput("next_pc", {27'd0, pc}, {27'd0, nextPc});
            mPc = nextPc;
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        alu_zero = 1'b0;
        mPc      = 5'd0;
        mIllegal = 1'b0;
        mHalted  = 1'b0;
        for (int i = 0; i < 32; i++) imem[i] = 32'd0;

        imem[0]  = enc(6'b110000, 5'd0, 5'd0, 5'd10, 11'd10);
        imem[1]  = enc(6'b000010, 5'd9, 5'd17, 5'd3, 11'h7E3);
        imem[3]  = enc(6'b111111, 5'd1, 5'd2, 5'd3, 11'd4);
        imem[5]  = enc(6'b000010, 5'd0, 5'd0, 5'd0, 11'd12);
        imem[12] = enc(6'b000010, 5'd0, 5'd0, 5'd0, 11'd14);
        imem[14] = enc(6'b001000, 5'd4, 5'd5, 5'd0, 11'd7);
        imem[7]  = enc(6'b000010, 5'd0, 5'd0, 5'd0, 11'd14);
        imem[15] = enc(6'b000010, 5'd0, 5'd0, 5'd0, 11'd31);
        imem[31] = enc(6'b010000, 5'd1, 5'd2, 5'd3, 11'd0);

        tick();
        tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // Directed walk: ADDI, J with junk upper bits, illegal, NOP with a
        // start poke while busy, J 12, BEQ taken/not taken, ADD at the top.
        doStart();
        runInstr(1'b0, 1'b0);
        runInstr(1'b0, 1'b0);
        runInstr(1'b0, 1'b0);
        runInstr(1'b0, 1'b1);
        runInstr(1'b1, 1'b0);
        runInstr(1'b0, 1'b0);
        runInstr(1'b1, 1'b0);
        runInstr(1'b0, 1'b0);
        runInstr(1'b0, 1'b0);
        runInstr(1'b1, 1'b0);
        runInstr(1'b0, 1'b0);
        checkOutput("final_halted", {31'd0, mHalted}, {31'd0, halted});
        tick();
        checkOutput("halt_hold_pc", {27'd0, pc}, 32'd31);

        // Restart from HALT, then reset in the middle of the ADDI's WB cycle.
        doStart();
        checkOutput("restart_busy", {31'd0, busy}, 32'd1);
        checkOutput("restart_pc", {27'd0, pc}, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("pre_abort_regwrite", {31'd0, regWrite}, 32'd1);
        reset = 1'b1;
        #1;
        checkResetValues("abort");
        tick();
        reset = 1'b0;
        tick();
        checkOutput("abort_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_idle_regwrite", {31'd0, regWrite}, 32'd0);

        // Random program: mix of every opcode class plus undefined opcodes.
        for (int i = 0; i < 32; i++) begin
            logic [5:0] op;
            case ($urandom_range(0, 7))
                0: op = 6'b110000;
                1: op = 6'b111000;
                2: op = 6'b010000;
                3: op = 6'b100000;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: op = 6'b000000;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (!refDecode(op).bad) op = 6'($urandom_range(0, 63));
                end
            endcase
            imem[i] = {op, 26'($urandom)};
        end
        doStart();
        for (int n = 0; n < 120; n++) begin
            if (mHalted) doStart();
            runInstr(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter PC_W, default 5: program counter width, giving a 32-word instruction space.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset and on start.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins execution from RESET_PC; honoured only in IDLE or HALT.
REQ-006 instr  input  32  instruction word returned combinationally by instruction memory for the current pc.
REQ-007 alu_zero  input  1  datapath ALU zero flag, valid during EXEC.
REQ-008 pc  output  PC_W  instruction memory address.
REQ-009 ir  output  32  latched instruction register.
REQ-010 rs_addr / rt_addr / rd_addr  output  5 each  ir[25:21] / ir[20:16] / ir[15:11].
REQ-011 imm  output  32  ir[10:0] zero-extended.
REQ-012 alu_op  output  3  ADD=000, SUB=001, SHL=010, NOP=111.
REQ-013 alu_src_imm  output  1  1 selects imm as ALU operand B.
REQ-014 reg_write  output  1  register-file write strobe, pulsed for one cycle.
REQ-015 busy  output  1  high in FETCH, DECODE, EXEC or WB.
REQ-016 halted  output  1  high in HALT.
REQ-017 illegal  output  1  sticky flag for an undefined opcode.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-019 IDLE->FETCH on start, with pc<=RESET_PC and illegal cleared.
REQ-020 HALT->FETCH on start, with the same pc load and illegal clear.
REQ-021 In FETCH, ir SHALL load instr; the next state is DECODE.
REQ-022 In DECODE, alu_op and alu_src_imm SHALL be decoded from ir[31:26]; the next state is EXEC.
REQ-023 Opcode map (ir[31:26]):
- 110000 ADDI: ADD, imm operand, writes.
- 111000 SUBI: SUB, imm operand, writes.
- 010000 ADD: ADD, register operand, writes.
- 100000 SHIFTL: SHL, register operand, writes.
- 001000 BEQ: SUB, register operand, no write.
- 000010 J: no write.
- 000000 NOP: no write.
REQ-024 Any other opcode SHALL execute as NOP and set illegal, which stays high until reset or start.
REQ-025 alu_op and alu_src_imm SHALL hold from DECODE through WB.
REQ-026 EXEC->WB for writing opcodes; EXEC->FETCH otherwise.
REQ-027 reg_write SHALL be high only during WB; WB->FETCH.
REQ-028 PC update in EXEC (non-writing opcodes) or WB (writing opcodes), chosen in this priority:
- J: pc<=ir[PC_W-1:0]; upper target bits are ignored.
- BEQ with alu_zero=1: pc<=ir[PC_W-1:0] (absolute target).
- otherwise: pc<=pc+1.
REQ-029 When a non-taken instruction at pc=2^PC_W-1 completes, the block SHALL enter HALT with pc unchanged (no wrap-around).
REQ-030 J or taken BEQ at the last address SHALL jump normally.
REQ-031 A start pulse while busy SHALL be ignored.
REQ-032 Latency SHALL be 4 cycles for writing instructions and 3 cycles for J, BEQ and NOP.

Reset
REQ-033 Reset SHALL force IDLE immediately, regardless of state.
REQ-034 Reset values: pc=RESET_PC, ir=0, alu_op=NOP, alu_src_imm=0, reg_write=0, busy=0, halted=0, illegal=0.
REQ-035 Reset asserted mid-instruction SHALL abort the instruction with no reg_write pulse.

Structure
REQ-036 A shared package SHALL hold the opcode constants, alu_op encodings, the state enum and the field bit positions.
REQ-037 A combinational sub-module opcode_decoder SHALL map an opcode to {alu_op, alu_src_imm, writes, is_jump, is_branch, illegal}.

Verification
REQ-038 Program ADDI R10,R0,10 at address 0, then start:
- FETCH/DECODE/EXEC/WB sequence occurs.
- reg_write pulses in the 4th cycle with rd_addr=10, imm=10, alu_src_imm=1, alu_op=000.
- pc=1 afterwards.
REQ-039 J 12 at address 5 -> pc=12 after EXEC, no reg_write pulse, 3-cycle latency.
REQ-040 BEQ R4,R5,7 at address 14:
- alu_zero=1 -> pc=7.
- alu_zero=0 -> pc=15.
- alu_op=001 in both cases.
REQ-041 Opcode 111111 at address 3 -> illegal=1, no write, pc=4; illegal stays set until the next start.
REQ-042 ADD at address 31 -> reg_write pulse, then halted=1 with pc=31; a subsequent start gives pc=0 and busy=1.
REQ-043 Reset asserted during WB -> reg_write=0 in the same cycle, state IDLE, all outputs at reset values.
